// File: rtl/draw_pkg.sv
// draw_pkg: shared constants and types for the column draw sequencers.
//   - colour constants for the three cell kinds plus black
//   - 2-bit cell-code type and FSM state type
//   - screen geometry of the 160x120 VGA adapter
package draw_pkg;

  localparam logic [2:0] COL_BG     = 3'b011;
  localparam logic [2:0] COL_MEAT   = 3'b010;
  localparam logic [2:0] COL_HAZARD = 3'b100;
  localparam logic [2:0] COL_BLACK  = 3'b000;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [1:0] cell_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DRAW = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cell_colour_map.sv
// cell_colour_map: combinational translation of a 2-bit cell code into the
// 3-bit RGB colour used by the VGA adapter.
//   code   in  2  cell code (00 background, 01 meat, 10 hazard, 11 background)
//   colour out 3  RGB colour
module cell_colour_map
  import draw_pkg::*;
(
  input  cell_code_t code,
  output logic [2:0] colour
);

  // code-to-colour lookup; code 11 is drawn as background
  always_comb begin
    colour = COL_BG;
    case (code)
      2'b00:   colour = COL_BG;
      2'b01:   colour = COL_MEAT;
      2'b10:   colour = COL_HAZARD;
      2'b11:   colour = COL_BG;
      default: colour = COL_BG;
    endcase
  end

endmodule

// File: rtl/column_draw_ctrl.sv
// column_draw_ctrl: walks every pixel of a column of CELLS square cells and
// issues one plot request per pixel to the VGA adapter.
//   clk, reset (async, active low)
//   start     in   request a draw, sampled only in IDLE
//   col_data  in   column contents, 2 bits per cell, cell 0 at the top
//   x_base    in   left pixel x of the column
//   grant     in   pending pixel is consumed on this cycle's rising edge
//   x, y, colour, plot  out  pixel request to the adapter
//   busy      out  high from the first cycle of DRAW through DONE
//   done      out  one-cycle pulse after the last pixel is consumed
// Optional feature: define CELL_BORDER_EN to draw a 1-pixel black grid
// (px = 0 or py = 0 of each cell plotted as black).
module column_draw_ctrl
  import draw_pkg::*;
#(
  parameter int CELLS     = 14,
  parameter int CELL_LOG2 = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*CELLS-1:0] col_data,
  input  logic [7:0]         x_base,
  input  logic               grant,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(CELLS);
  localparam logic [CELL_LOG2-1:0] P_MAX    = {CELL_LOG2{1'b1}};
  localparam logic [CW-1:0]        CELL_MAX = CW'(CELLS - 1);

  state_t                 state_r, state_nx;
  logic [2*CELLS-1:0]     col_r;
  logic [7:0]             xb_r;
  logic [CW-1:0]          cell_r;
  logic [CELL_LOG2-1:0]   py_r, px_r;
  logic                   consume_s, last_s;
  cell_code_t             code_s;
  logic [2:0]             map_colour_s, pix_colour_s;

  assign consume_s = (state_r == DRAW) && grant;
  assign last_s    = (cell_r == CELL_MAX) && (py_r == P_MAX) && (px_r == P_MAX);
  assign code_s    = col_r[{cell_r, 1'b0} +: 2];

  cell_colour_map u_map (
    .code   (code_s),
    .colour (map_colour_s)
  );

`ifdef CELL_BORDER_EN
  assign pix_colour_s = ((px_r == '0) || (py_r == '0)) ? COL_BLACK : map_colour_s;
`else
  assign pix_colour_s = map_colour_s;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = start ? DRAW : IDLE;
      DRAW:    state_nx = (grant && last_s) ? DONE : DRAW;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // snapshot on accepted start, then advance px fastest, then py, then cell
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r  <= '0;
      xb_r   <= 8'd0;
      cell_r <= '0;
      py_r   <= '0;
      px_r   <= '0;
    end else if ((state_r == IDLE) && start) begin
      col_r  <= col_data;
      xb_r   <= x_base;
      cell_r <= '0;
      py_r   <= '0;
      px_r   <= '0;
    end else if (consume_s) begin
      px_r <= px_r + 1'b1;
      if (px_r == P_MAX) begin
        py_r <= py_r + 1'b1;
        if (py_r == P_MAX) cell_r <= cell_r + 1'b1;
      end
    end
  end

  // outputs decoded from registered state and counters only; zero outside DRAW
  always_comb begin
    x      = 8'd0;
    y      = 7'd0;
    colour = 3'b000;
    plot   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_r)
      DRAW: begin
        x      = xb_r + 8'(px_r);
        y      = 7'({cell_r, py_r});
        colour = pix_colour_s;
        plot   = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        x = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_column_draw_ctrl.sv
// tb_column_draw_ctrl: directed bench with a pixel scoreboard for column_draw_ctrl.
module tb_column_draw_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, grant;
  logic [27:0] col_data;
  logic [7:0]  x_base;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int total = 0;
  int bad   = 0;
  int pix_cnt = 0;
  logic [17:0] sb[$];

  column_draw_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .col_data(col_data),
    .x_base(x_base), .grant(grant), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_col(input logic [1:0] c, input int px, input int py);
    logic [2:0] r;
    case (c)
      2'b01:   r = 3'b010;
      2'b10:   r = 3'b100;
      default: r = 3'b011;
    endcase
`ifdef CELL_BORDER_EN
    if (px == 0 || py == 0) r = 3'b000;
`endif
    return r;
  endfunction

  task automatic push_column(input logic [27:0] cd, input logic [7:0] xb);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [1:0] code;
    for (int c = 0; c < 14; c++) begin
      code = cd[2*c +: 2];
      for (int py = 0; py < 8; py++)
        for (int px = 0; px < 8; px++) begin
          ex = xb + 8'(px);
          ey = 7'(c * 8 + py);
          sb.push_back({ex, ey, exp_col(code, px, py)});
        end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every consumed pixel must be the next expected one
  always @(negedge clk) begin
    logic [17:0] e;
    if (reset === 1'b1 && plot === 1'b1 && grant === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL extra_pixel got x=%0d y=%0d c=%0d want none", x, y, colour);
      end else begin
        e = sb.pop_front();
        assert ({x, y, colour} === e) else begin
          bad++;
          $error("FAIL pixel%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                 pix_cnt, x, y, colour, e[17:10], e[9:3], e[2:0]);
        end
      end
      pix_cnt++;
    end
  end

  // mode 0: grant high; mode 1: grant toggles; mode 2: start/col_data disturbed mid-draw
  task automatic run(input string tag, input int mode, input int lo, input int hi);
    int k;
    bit seen;
    pix_cnt = 0;
    push_column(col_data, x_base);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_plot_n1"}, 32'(plot), 32'd1);
    check({tag, "_busy_n1"}, 32'(busy), 32'd1);
    check({tag, "_x_first"}, 32'(x), 32'(x_base));
    check({tag, "_y_first"}, 32'(y), 32'd0);
    k = 1;
    seen = 1'b0;
    while (k < 5000 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (mode == 1) grant = (k % 2 == 1);
        if (mode == 2) begin
          if (k == 5) begin
            start = 1'b1;
            col_data = ~col_data;
            x_base = x_base + 8'd3;
          end else start = 1'b0;
        end
        tick();
        k++;
      end
    end
    grant = 1'b1;
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    total++;
    assert (k >= lo && k <= hi) else begin
      bad++;
      $error("FAIL %s_done_cycle got=%0d want=%0d..%0d", tag, k, lo, hi);
    end
    check({tag, "_pixels"}, 32'(pix_cnt), 32'd896);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_plot_done"}, 32'(plot), 32'd0);
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_plot"}, 32'(plot), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    grant = 1'b1;
    col_data = 28'd0;
    x_base = 8'd0;
    #22;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    col_data = 28'h0000000; x_base = 8'd20;
    run("bg", 0, 897, 897);
    check("bg_last_x", 32'(x), 32'd0);

    col_data = 28'h0000009; x_base = 8'd0;
    run("map", 0, 897, 897);

    col_data = 28'($urandom); x_base = 8'd50;
    run("toggle", 1, 1791, 1793);

    col_data = 28'($urandom); x_base = 8'd100;
    run("ignore", 2, 897, 897);

    // reset in the middle of a draw
    col_data = 28'h5A5A5A5; x_base = 8'd30;
    pix_cnt = 0;
    push_column(col_data, x_base);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (pix_cnt < 300 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_reached300", 32'(pix_cnt), 32'd300);
    #2;
    reset = 1'b0;
    #1;
    check("abort_x", 32'(x), 32'd0);
    check("abort_y", 32'(y), 32'd0);
    check("abort_colour", 32'(colour), 32'd0);
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || plot) n++;
      tick();
    end
    check("abort_no_done", 32'(n), 32'd0);

    col_data = 28'hABCDEF1; x_base = 8'd20;
    run("redraw", 0, 897, 897);

    col_data = 28'($urandom); x_base = 8'd252;
    run("wrap", 0, 897, 897);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the sequence itself stalls
  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/column_draw_ctrl.md
# column_draw_ctrl

Sequencer that renders one falling-square column onto the 160x120 VGA adapter. On `start` it snapshots a 28-bit column register: 14 cells, 2 bits each, cell 0 at the top. It then walks every pixel of every 8x8 cell and issues one plot request per pixel, with the cell's colour, to the VGA adapter's x/y/colour/plot inputs. It sits between the vertical column registers and the VGA adapter. A `grant` input lets a higher-level arbiter share the adapter among several columns.

## Interface
- `CELLS`, default 14: cells per column. The column register is 2*`CELLS` bits wide.
- `CELL_LOG2`, default 3: log2 of the cell edge in pixels, so cells are 8x8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to draw; sampled only in IDLE.
- `col_data`  in  28  column contents; bits [2i+1:2i] hold the code for cell i.
- `x_base`  in  8  left pixel x of the column.
- `grant`  in  1  adapter access; when high, the pending pixel is consumed this cycle.
- `x`  out  8  pixel x to the adapter.
- `y`  out  7  pixel y to the adapter.
- `colour`  out  3  RGB colour to the adapter.
- `plot`  out  1  pixel request valid.
- `busy`  out  1  high from the first cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last pixel is consumed.

## Operation
- States and transitions:
  - IDLE → DRAW on `start`=1.
  - DRAW → DONE when the last pixel is consumed (cell = `CELLS`-1, py = 7, px = 7, `grant`=1).
  - DONE → IDLE unconditionally.
- On acceptance the block latches `col_data` and `x_base` into internal registers and clears cell, py and px to 0. Later changes on those inputs have no effect until the next accepted `start`.
- Per-pixel outputs in DRAW:
  - `x` = latched `x_base` + px, 8-bit, wraps modulo 256, no clamping.
  - `y` = {cell, py} = cell*8 + py; the maximum is 111.
- Colour map for the cell code: 00→3'b011, 01→3'b010, 10→3'b100, 11→3'b011.
- Scan order: px increments fastest (0..7), then py, then cell.
- `plot` = 1 exactly while the state is DRAW.
- A pixel is consumed on a rising edge where `plot`=1 and `grant`=1. With `grant`=0, the counters and outputs hold.
- `start` is ignored in DRAW and DONE; there is no queueing.
- Reset values: state IDLE; `x`, `y`, `colour`, `plot`, `busy`, `done` all 0; counters and latched data 0.
- Reset asserted mid-draw aborts immediately. No `done` is issued; remaining pixels are lost.

## Timing
- `start` sampled high at edge N → `plot`=1 and `busy`=1 from cycle N+1.
- With `grant` tied high, `plot` stays high through cycle N+896 (14*64 pixels), `done`=1 in cycle N+897, and IDLE from N+898.
- A `start` at N+898 is accepted.
- Each low-`grant` cycle in DRAW adds exactly one cycle of latency.
- `x`, `y` and `colour` are stable for the whole cycle in which `plot`=1.
- `x`, `y` and `colour` are driven from registered counters only; there is no combinational path from `grant`.

## Configuration
- `CELL_BORDER_EN`:
  - Defined: any pixel with px = 0 or py = 0 inside a cell is plotted with colour 3'b000, which gives a 1-pixel black grid between squares.
  - Undefined: every pixel uses the mapped cell colour.
- Pixel count and timing are identical either way.

## Structure
- Package `draw_pkg` holds:
  - colour constants `COL_BG`=3'b011, `COL_MEAT`=3'b010, `COL_HAZARD`=3'b100, `COL_BLACK`=3'b000;
  - the 2-bit cell-code typedef;
  - the FSM state typedef (IDLE, DRAW, DONE);
  - `SCREEN_W`=160 and `SCREEN_H`=120.
- One sub-module `cell_colour_map`: combinational, 2-bit code in, 3-bit colour out. It is reused by other draw sequencers.

## Test plan
- Reset, then `start` with `col_data`=0 and `x_base`=20, `grant`=1:
  - exactly 896 plot cycles, all with `colour`=3'b011;
  - first pixel (20,0), last pixel (27,111);
  - `done` in cycle N+897.
- `col_data`=28'h0000009 (cell0=01, cell1=10), `x_base`=0:
  - y 0..7 → 3'b010;
  - y 8..15 → 3'b100;
  - y ≥ 16 → 3'b011.
- Toggle `grant` 1/0 every cycle:
  - still exactly 896 consumed pixels in scan order;
  - `done` at N+1+2*896-1 ±1 according to phase;
  - no pixel is repeated or skipped.
- Pulse `start` during DRAW and change `col_data` during DRAW → both ignored; output matches the first snapshot.
- Assert `reset` at pixel 300 → all outputs 0 asynchronously and no `done`; a subsequent `start` redraws from (x_base, 0).
- `x_base`=252 → `x` wraps 252..255,0..3 per row. With `CELL_BORDER_EN`, the px=0 and py=0 pixels show 3'b000.
